// File: rtl/mem_pkg.sv
// Shared types and constants for the multi-cycle unified memory responder.
package mem_pkg;

  typedef enum logic [1:0] {
    MS_IDLE,
    MS_WAIT,
    MS_RESP
  } mem_state_t;

  localparam logic [31:0] MISALIGN_PATTERN = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_array.sv
// Synchronous single-port word RAM: registered read, write on the same edge, no reset.
module mem_array #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned DATA_W      = 32
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
  input  logic [DATA_W-1:0]              wdata,
  output logic [DATA_W-1:0]              rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[idx] <= wdata;
    end
    rdata_q <= mem_q[idx];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Multi-cycle unified memory responder with fixed access latency and a one-cycle mem_ready.
// Optional build macro MISALIGN_CHK_EN adds the misaligned port and alignment checking.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned DATA_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [31:0]       adr,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              mem_ready,
`ifdef MISALIGN_CHK_EN
  output logic              misaligned,
`endif
  output logic              busy
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);
  // The accept cycle is the first latency cycle, so WAIT lasts LATENCY-1 cycles.
  localparam logic [3:0] WaitLast = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  mem_state_t        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IdxW-1:0]   idx_q, idx_d, ram_idx;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] read_data_q, read_data_d;
  logic [DATA_W-1:0] ram_rdata, resp_rdata;
  logic              wr_q, wr_d;
  logic              mis_q, mis_d;
  logic              accept, adr_mis, ram_we;

`ifdef MISALIGN_CHK_EN
  assign adr_mis    = |adr[1:0];
  assign misaligned = mis_q;
  logic unused_adr;
  assign unused_adr = ^adr[31:IdxW+2];
`else
  assign adr_mis = 1'b0;
  logic unused_adr;
  assign unused_adr = ^{adr[31:IdxW+2], adr[1:0]};
`endif

  assign accept = (state_q == MS_IDLE) && (memread || memwrite);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    mis_d   = mis_q;
    case (state_q)
      MS_IDLE: begin
        if (accept) begin
          idx_d   = adr[IdxW+1:2];
          wdata_d = write_data;
          wr_d    = memwrite;  // read+write together is a write
          mis_d   = adr_mis;
          cnt_d   = 4'd0;
          state_d = (LATENCY == 1) ? MS_RESP : MS_WAIT;
        end
      end
      MS_WAIT: begin
        if (cnt_q == WaitLast) begin
          state_d = MS_RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      MS_RESP: begin
        state_d = MS_IDLE;
        mis_d   = 1'b0;
      end
      default: state_d = MS_IDLE;
    endcase
  end

  // In IDLE the RAM is pointed at the live address so a LATENCY of 1 still has data in RESP.
  assign ram_idx = (state_q == MS_IDLE) ? adr[IdxW+1:2] : idx_q;
  assign ram_we  = (state_q == MS_RESP) && wr_q && !mis_q;

  mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .DATA_W     (DATA_W)
  ) u_mem_array (
    .clk  (clk),
    .we   (ram_we),
    .idx  (ram_idx),
    .wdata(wdata_q),
    .rdata(ram_rdata)
  );

  assign resp_rdata  = mis_q ? DATA_W'(MISALIGN_PATTERN) : ram_rdata;
  assign read_data_d = ((state_q == MS_RESP) && !wr_q) ? resp_rdata : read_data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= MS_IDLE;
      cnt_q       <= 4'd0;
      idx_q       <= '0;
      wdata_q     <= '0;
      wr_q        <= 1'b0;
      mis_q       <= 1'b0;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      wr_q        <= wr_d;
      mis_q       <= mis_d;
      read_data_q <= read_data_d;
    end
  end

  assign read_data = read_data_d;
  assign mem_ready = (state_q == MS_RESP);
  assign busy      = (state_q != MS_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder against a word-array reference model.
module tb_mem_responder;

  localparam int unsigned DEPTH_WORDS = 1024;
  localparam int unsigned LATENCY     = 2;
  localparam int unsigned DATA_W      = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        memread, memwrite;
  logic [31:0] adr, write_data, read_data;
  logic        mem_ready, busy, misaligned;

  int errors = 0;
  int checks = 0;

  logic [31:0] model [int unsigned];
  logic [31:0] last_rd;

  always #5 clk = ~clk;

  mem_responder #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .LATENCY    (LATENCY),
    .DATA_W     (DATA_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .memread   (memread),
    .memwrite  (memwrite),
    .adr       (adr),
    .write_data(write_data),
    .read_data (read_data),
    .mem_ready (mem_ready),
`ifdef MISALIGN_CHK_EN
    .misaligned(misaligned),
`endif
    .busy      (busy)
  );

`ifndef MISALIGN_CHK_EN
  assign misaligned = 1'b0;
`endif

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit is_mis(input logic [31:0] a);
`ifdef MISALIGN_CHK_EN
    return a[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  // One request from IDLE to completion; inputs are scrambled while busy.
  task automatic xfer(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                      input string tag);
    int          n;
    bit          seen;
    int unsigned idx;
    bit          mis;
    logic [31:0] exp;
    idx = (a >> 2) % DEPTH_WORDS;
    mis = is_mis(a);
    @(negedge clk);
    memread = rd; memwrite = wr; adr = a; write_data = d;
    n = 0;
    seen = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (mem_ready) begin
        seen = 1;
      end else begin
        check_eq({tag, "/busy_wait"}, {31'd0, busy}, 32'd1);
        memread = 1'($urandom()); memwrite = 1'($urandom());
        adr = $urandom(); write_data = $urandom();
      end
    end
    check_eq({tag, "/ready"}, {31'd0, seen}, 32'd1);
    if (seen) begin
      check_eq({tag, "/lat"}, n, LATENCY);
      check_eq({tag, "/busy_resp"}, {31'd0, busy}, 32'd1);
      if (wr) begin
        if (!mis) model[idx] = d;
        check_eq({tag, "/rd_held"}, read_data, last_rd);
      end else begin
        exp = mis ? 32'hDEAD_BEEF : (model.exists(idx) ? model[idx] : 32'h0);
        check_eq({tag, "/rdata"}, read_data, exp);
        last_rd = exp;
      end
`ifdef MISALIGN_CHK_EN
      check_eq({tag, "/mis"}, {31'd0, misaligned}, {31'd0, mis});
`endif
    end
    memread = 0; memwrite = 0;
    @(negedge clk);
    check_eq({tag, "/one_pulse"}, {31'd0, mem_ready}, 32'd0);
    check_eq({tag, "/idle"}, {31'd0, busy}, 32'd0);
    check_eq({tag, "/mis_clr"}, {31'd0, misaligned}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int pt [3];
    int npulse, t, lowcnt;
    logic [31:0] a;

    reset = 1; memread = 0; memwrite = 0; adr = 0; write_data = 0; last_rd = 0;
    repeat (3) @(negedge clk);
    check_eq("rst/read_data", read_data, 32'h0);
    check_eq("rst/mem_ready", {31'd0, mem_ready}, 32'd0);
    check_eq("rst/busy", {31'd0, busy}, 32'd0);
    check_eq("rst/misaligned", {31'd0, misaligned}, 32'd0);
    reset = 0;

    xfer(0, 1, 32'h10, 32'hCAFE_0001, "basic_wr");
    xfer(1, 0, 32'h10, 32'h0, "basic_rd");

    xfer(0, 1, DEPTH_WORDS * 4 + 8, 32'h1111_1111, "wrap_wr");
    xfer(1, 0, 32'h8, 32'h0, "wrap_rd");

    xfer(1, 1, 32'h30, 32'hB0B0_0030, "both_hi");
    xfer(1, 0, 32'h30, 32'h0, "both_rd");

    // Continuous memread: pulses every LATENCY+1 cycles with one idle cycle between.
    xfer(0, 1, 32'h40, 32'h4040_4040, "b2b_wr");
    @(negedge clk);
    memread = 1; adr = 32'h40;
    t = 0; npulse = 0; lowcnt = 0;
    while (npulse < 3 && t < 40) begin
      @(negedge clk);
      t++;
      if (mem_ready) begin
        pt[npulse] = t;
        check_eq("b2b/rdata", read_data, 32'h4040_4040);
        npulse++;
        if (npulse == 3) memread = 0;
      end else if (npulse == 1 && !busy) begin
        lowcnt++;
      end
    end
    last_rd = 32'h4040_4040;
    check_eq("b2b/pulses", npulse, 3);
    if (npulse == 3) begin
      check_eq("b2b/first", pt[0], LATENCY);
      check_eq("b2b/gap1", pt[1] - pt[0], LATENCY + 1);
      check_eq("b2b/gap2", pt[2] - pt[1], LATENCY + 1);
    end
    check_eq("b2b/busy_low", lowcnt, 1);
    @(negedge clk);
    check_eq("b2b/idle", {31'd0, busy}, 32'd0);

    // Reset in the middle of a write must drop it.
    xfer(0, 1, 32'h20, 32'h5, "rst_pre");
    @(negedge clk);
    memwrite = 1; adr = 32'h20; write_data = 32'hBAD0_0BAD;
    @(negedge clk);
    memwrite = 0;
    check_eq("rst_mid/busy_before", {31'd0, busy}, 32'd1);
    #2 reset = 1;
    #1;
    check_eq("rst_mid/busy", {31'd0, busy}, 32'd0);
    check_eq("rst_mid/mem_ready", {31'd0, mem_ready}, 32'd0);
    check_eq("rst_mid/read_data", read_data, 32'h0);
    last_rd = 0;
    @(negedge clk);
    reset = 0;
    xfer(1, 0, 32'h20, 32'h0, "rst_rd");

`ifdef MISALIGN_CHK_EN
    xfer(1, 0, 32'h13, 32'h0, "mis_rd");
    xfer(0, 1, 32'h22, 32'h7777_7777, "mis_wr");
    xfer(1, 0, 32'h20, 32'h0, "mis_chk");
`endif

    // Prefill a small window, then mixed random traffic with random upper address bits.
    for (int i = 0; i < 16; i++) begin
      a = $urandom();
      a[11:2] = 10'(i);
      a[1:0] = 2'b00;
      xfer(0, 1, a, $urandom(), "fill");
    end
    for (int k = 0; k < 40; k++) begin
      int unsigned op;
      a = $urandom();
      a[11:2] = 10'($urandom_range(0, 15));
`ifndef MISALIGN_CHK_EN
      a[1:0] = 2'($urandom());
`else
      a[1:0] = 2'b00;
`endif
      op = $urandom_range(0, 2);
      xfer(op != 1, op != 0, a, $urandom(), $sformatf("rand%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
